// File: rtl/mem_mux_tracked_pkg.sv
// Shared constants and helpers for the tracked memory multiplexer.
// Holds the arbitration mode encodings used by the ARB_MODE parameter.
package mem_mux_tracked_pkg;

  localparam int ARB_ROUND_ROBIN    = 0;
  localparam int ARB_FIXED_PRIORITY = 1;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_mux_tracked_order_fifo.sv
// Order tracker: remembers which upstream port owns each outstanding read,
// so downstream results can be routed back in command order.
module mem_mux_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push && (count != COUNT_W'(DEPTH));
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_mux_tracked.sv
// Merges several upstream memory command streams into one registered
// downstream stream and routes in-order read results back to their owners.
module mem_mux_tracked
  import mem_mux_tracked_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 1,
  parameter int SLAVE_PORTS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = ARB_ROUND_ROBIN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SLAVE_PORTS-1:0]            slave_command_valid,
  output logic [SLAVE_PORTS-1:0]            slave_command_ready,
  input  logic [SLAVE_PORTS-1:0]            slave_command_read_enable,
  input  logic [SLAVE_PORTS-1:0]            slave_command_write_enable,
  input  logic [SLAVE_PORTS*ADDR_WIDTH-1:0] slave_command_addr,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0] slave_command_data,
  input  logic [SLAVE_PORTS*MASK_WIDTH-1:0] slave_command_mask,
  input  logic [SLAVE_PORTS*ID_WIDTH-1:0]   slave_command_id,
  output logic [SLAVE_PORTS-1:0]            slave_result_valid,
  input  logic [SLAVE_PORTS-1:0]            slave_result_ready,
  output logic [SLAVE_PORTS*DATA_WIDTH-1:0] slave_result_data,
  output logic [SLAVE_PORTS*ID_WIDTH-1:0]   slave_result_id,
  output logic                              master_command_valid,
  input  logic                              master_command_ready,
  output logic                              master_command_read_enable,
  output logic                              master_command_write_enable,
  output logic [ADDR_WIDTH-1:0]             master_command_addr,
  output logic [DATA_WIDTH-1:0]             master_command_data,
  output logic [MASK_WIDTH-1:0]             master_command_mask,
  output logic [ID_WIDTH-1:0]               master_command_id,
  input  logic                              master_result_valid,
  output logic                              master_result_ready,
  input  logic [DATA_WIDTH-1:0]             master_result_data,
  input  logic [ID_WIDTH-1:0]               master_result_id,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              error
);

  localparam int PW = $clog2(SLAVE_PORTS);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  if (SLAVE_PORTS < 2) begin : g_chk_ports
    $error("mem_mux_tracked: SLAVE_PORTS must be greater than 1");
  end
  if (!is_pow2(MAX_OUTSTANDING) || MAX_OUTSTANDING < 2) begin : g_chk_depth
    $error("mem_mux_tracked: MAX_OUTSTANDING must be a power of two and at least 2");
  end

  logic [ADDR_WIDTH-1:0] cmd_addr [SLAVE_PORTS];
  logic [DATA_WIDTH-1:0] cmd_data [SLAVE_PORTS];
  logic [MASK_WIDTH-1:0] cmd_mask [SLAVE_PORTS];
  logic [ID_WIDTH-1:0]   cmd_id   [SLAVE_PORTS];
  logic [SLAVE_PORTS-1:0] eligible;
  logic                   tracker_full;
  logic                   grant_valid;
  logic [PW-1:0]          grant_idx;
  logic [PW-1:0]          last_granted;
  logic                   out_free;
  logic                   take;
  logic                   push;
  logic                   pop;
  logic [PW-1:0]          fifo_head;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  int                     rr_cand;

  assign tracker_full = (fifo_count == CW'(MAX_OUTSTANDING));

  // Reads need tracker room; the check uses the current count only, so a
  // same-cycle pop never frees a slot early.
  for (genvar g = 0; g < SLAVE_PORTS; g++) begin : g_port
    assign cmd_addr[g] = slave_command_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign cmd_data[g] = slave_command_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign cmd_mask[g] = slave_command_mask[g*MASK_WIDTH +: MASK_WIDTH];
    assign cmd_id[g]   = slave_command_id[g*ID_WIDTH +: ID_WIDTH];
    assign eligible[g] = slave_command_valid[g] &&
                         (!slave_command_read_enable[g] || !tracker_full);
    assign slave_command_ready[g] = take && (grant_idx == PW'(g));
    assign slave_result_data[g*DATA_WIDTH +: DATA_WIDTH] = master_result_data;
    assign slave_result_id[g*ID_WIDTH +: ID_WIDTH]       = master_result_id;
  end

  // Loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_cand     = 0;
    if (ARB_MODE == ARB_FIXED_PRIORITY) begin
      for (int i = SLAVE_PORTS - 1; i >= 0; i--) begin
        if (eligible[PW'(i)]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(i);
        end
      end
    end else begin
      for (int k = SLAVE_PORTS; k >= 1; k--) begin
        rr_cand = int'(last_granted) + k;
        if (rr_cand >= SLAVE_PORTS) rr_cand = rr_cand - SLAVE_PORTS;
        if (eligible[PW'(rr_cand)]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(rr_cand);
        end
      end
    end
  end

  assign out_free = !master_command_valid || master_command_ready;
  assign take     = rst && out_free && grant_valid;
  assign push     = take && slave_command_read_enable[grant_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      master_command_valid <= 1'b0;
      last_granted         <= PW'(SLAVE_PORTS - 1);
    end else begin
      if (out_free) master_command_valid <= take;
      if (take)     last_granted         <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      master_command_read_enable  <= slave_command_read_enable[grant_idx];
      master_command_write_enable <= slave_command_write_enable[grant_idx];
      master_command_addr         <= cmd_addr[grant_idx];
      master_command_data         <= cmd_data[grant_idx];
      master_command_mask         <= cmd_mask[grant_idx];
      master_command_id           <= cmd_id[grant_idx];
    end
  end

  // A result with nothing outstanding is swallowed so the downstream never stalls.
  always_comb begin
    master_result_ready = 1'b1;
    slave_result_valid  = '0;
    pop                 = 1'b0;
    if (!fifo_empty) begin
      master_result_ready           = slave_result_ready[fifo_head];
      slave_result_valid[fifo_head] = master_result_valid && rst;
      pop = master_result_valid && slave_result_ready[fifo_head];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      error <= 1'b0;
    end else if (master_result_valid && fifo_empty) begin
      error <= 1'b1;
    end
  end

  mem_mux_order_fifo #(
    .WIDTH (PW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (grant_idx),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign outstanding = fifo_count;

endmodule

// File: tb/tb_mem_mux_tracked.sv
// Scoreboard bench for mem_mux_tracked: one round-robin and one fixed-priority
// instance share stimulus; expected commands/results are queued as they are driven.
module tb_mem_mux_tracked;
  localparam int AW = 32, DW = 32, MW = 4, IW = 1, P = 2, MO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P-1:0] s_valid, s_re, s_we, sr_ready;
  logic [P*AW-1:0] s_addr;
  logic [P*DW-1:0] s_data;
  logic [P*MW-1:0] s_mask;
  logic [P*IW-1:0] s_id;
  logic m_ready, mr_valid;
  logic [DW-1:0] mr_data;
  logic [IW-1:0] mr_id;

  logic [P-1:0] s_ready, sr_valid, fp_s_ready, fp_sr_valid;
  logic [P*DW-1:0] sr_data, fp_sr_data;
  logic [P*IW-1:0] sr_id, fp_sr_id;
  logic m_valid, m_re, m_we, mr_ready, err;
  logic fp_m_valid, fp_m_re, fp_m_we, fp_mr_ready, fp_err;
  logic [AW-1:0] m_addr, fp_m_addr;
  logic [DW-1:0] m_data, fp_m_data;
  logic [MW-1:0] m_mask, fp_m_mask;
  logic [IW-1:0] m_id, fp_m_id;
  logic [2:0] outstanding, fp_outstanding;

  int n_checks = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_addr_q[$];
  int exp_port_q[$];
  logic [IW-1:0] exp_id_q[$];

  mem_mux_tracked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW),
    .SLAVE_PORTS(P), .MAX_OUTSTANDING(MO), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .slave_command_valid(s_valid), .slave_command_ready(s_ready),
    .slave_command_read_enable(s_re), .slave_command_write_enable(s_we),
    .slave_command_addr(s_addr), .slave_command_data(s_data),
    .slave_command_mask(s_mask), .slave_command_id(s_id),
    .slave_result_valid(sr_valid), .slave_result_ready(sr_ready),
    .slave_result_data(sr_data), .slave_result_id(sr_id),
    .master_command_valid(m_valid), .master_command_ready(m_ready),
    .master_command_read_enable(m_re), .master_command_write_enable(m_we),
    .master_command_addr(m_addr), .master_command_data(m_data),
    .master_command_mask(m_mask), .master_command_id(m_id),
    .master_result_valid(mr_valid), .master_result_ready(mr_ready),
    .master_result_data(mr_data), .master_result_id(mr_id),
    .outstanding(outstanding), .error(err));

  mem_mux_tracked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW),
    .SLAVE_PORTS(P), .MAX_OUTSTANDING(MO), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .slave_command_valid(s_valid), .slave_command_ready(fp_s_ready),
    .slave_command_read_enable(s_re), .slave_command_write_enable(s_we),
    .slave_command_addr(s_addr), .slave_command_data(s_data),
    .slave_command_mask(s_mask), .slave_command_id(s_id),
    .slave_result_valid(fp_sr_valid), .slave_result_ready(sr_ready),
    .slave_result_data(fp_sr_data), .slave_result_id(fp_sr_id),
    .master_command_valid(fp_m_valid), .master_command_ready(m_ready),
    .master_command_read_enable(fp_m_re), .master_command_write_enable(fp_m_we),
    .master_command_addr(fp_m_addr), .master_command_data(fp_m_data),
    .master_command_mask(fp_m_mask), .master_command_id(fp_m_id),
    .master_result_valid(mr_valid), .master_result_ready(fp_mr_ready),
    .master_result_data(mr_data), .master_result_id(mr_id),
    .outstanding(fp_outstanding), .error(fp_err));

  // Every task starts and ends just after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    s_valid = '0; s_re = '0; s_we = '0; s_addr = '0; s_data = '0; s_mask = '1; s_id = '0;
    sr_ready = '1; m_ready = 1'b1; mr_valid = 1'b0; mr_data = '0; mr_id = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic issue_read(input int p, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            output bit ok);
    s_valid = '0; s_re = '0; s_we = '0;
    s_valid[p] = 1'b1; s_re[p] = 1'b1;
    s_id[p*IW +: IW] = id; s_addr[p*AW +: AW] = addr;
    ok = 1'b0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (s_ready[p] === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = '0; s_re = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 2'b11; s_we = 2'b11; s_re = '0; m_ready = 1'b1; mr_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mvalid: got %b expected 0", m_valid); end
    n_checks++; if (s_ready !== 2'b00 || fp_s_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready: got %b/%b expected 00", s_ready, fp_s_ready); end
    n_checks++; if (sr_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_srvalid: got %b expected 00", sr_valid); end
    n_checks++; if (outstanding !== 3'd0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_state: outstanding %0d error %b expected 0 0", outstanding, err); end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_round_robin();
    int seq[P];
    int last, exp_port;
    logic [P-1:0] hs;
    logic [AW-1:0] exp_a;
    do_reset();
    exp_addr_q.delete();
    for (int p = 0; p < P; p++) begin
      seq[p] = 0; s_addr[p*AW +: AW] = AW'(p * 256); s_data[p*DW +: DW] = ~DW'(p * 256);
    end
    s_we = 2'b11; s_re = 2'b00; s_valid = 2'b11;
    last = P - 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      exp_port = (last + 1) % P;
      n_checks++; if (s_ready !== P'(1 << exp_port)) begin n_fail++; $display("[TB] FAIL rr_grant cyc %0d: got %b expected %b", cyc, s_ready, P'(1 << exp_port)); end
      if (cyc > 0) begin
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_throughput cyc %0d: got %b expected 1", cyc, m_valid); end
      end
      if (m_valid === 1'b1) begin
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        n_checks++; if (m_addr !== exp_a || m_data !== ~exp_a || m_we !== 1'b1 || m_re !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_cmd cyc %0d: got addr %h we %b expected addr %h we 1", cyc, m_addr, m_we, exp_a); end
      end
      exp_addr_q.push_back(AW'(exp_port * 256 + seq[exp_port]));
      last = exp_port;
      hs = s_ready;
      @(posedge clk); #1;
      for (int p = 0; p < P; p++) if (hs[p]) begin
        seq[p]++;
        s_addr[p*AW +: AW] = AW'(p * 256 + seq[p]); s_data[p*DW +: DW] = ~AW'(p * 256 + seq[p]);
      end
    end
    s_valid = '0;
  endtask

  task automatic test_fixed_priority();
    int seq[P];
    logic [P-1:0] hs;
    logic [AW-1:0] exp_a;
    do_reset();
    exp_addr_q.delete();
    for (int p = 0; p < P; p++) begin
      seq[p] = 0; s_addr[p*AW +: AW] = AW'(p * 256); s_data[p*DW +: DW] = ~DW'(p * 256);
    end
    s_we = 2'b11; s_re = 2'b00; s_valid = 2'b11;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      n_checks++; if (fp_s_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL fp_grant cyc %0d: got %b expected 01", cyc, fp_s_ready); end
      if (cyc > 0) begin
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        n_checks++; if (fp_m_valid !== 1'b1 || fp_m_addr !== exp_a) begin n_fail++; $display("[TB] FAIL fp_cmd cyc %0d: got valid %b addr %h expected 1 %h", cyc, fp_m_valid, fp_m_addr, exp_a); end
      end
      exp_addr_q.push_back(AW'(seq[0]));
      hs = fp_s_ready;
      @(posedge clk); #1;
      for (int p = 0; p < P; p++) if (hs[p]) begin
        seq[p]++;
        s_addr[p*AW +: AW] = AW'(p * 256 + seq[p]); s_data[p*DW +: DW] = ~AW'(p * 256 + seq[p]);
      end
    end
    s_valid = '0;
  endtask

  task automatic test_tracker_full();
    int hs;
    do_reset();
    s_valid = 2'b10; s_re = 2'b10; s_we = 2'b00; s_addr[AW +: AW] = 32'h40;
    hs = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (s_ready[1] === 1'b1) hs++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (hs != MO || outstanding !== 3'(MO)) begin n_fail++; $display("[TB] FAIL full_accept: got %0d accepted outstanding %0d expected %0d %0d", hs, outstanding, MO, MO); end
    n_checks++; if (s_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL full_block: got %b expected 00", s_ready); end
    @(posedge clk); #1;
    mr_valid = 1'b1; mr_data = 32'hCAFE0001; sr_ready = 2'b11;
    @(negedge clk);
    n_checks++; if (mr_ready !== 1'b1 || sr_valid !== 2'b10 || sr_data[DW +: DW] !== 32'hCAFE0001) begin n_fail++; $display("[TB] FAIL full_result: got ready %b srvalid %b data %h expected 1 10 cafe0001", mr_ready, sr_valid, sr_data[DW +: DW]); end
    n_checks++; if (s_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL full_no_bypass: got %b expected 00", s_ready); end
    @(posedge clk); #1;
    mr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 3'd3 || s_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL full_reopen: got outstanding %0d ready %b expected 3 10", outstanding, s_ready); end
    @(posedge clk); #1;
    s_valid = '0; s_re = '0;
    @(negedge clk);
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("[TB] FAIL full_refill: got %0d expected 4", outstanding); end
    @(posedge clk); #1;
    mr_valid = 1'b1;
    for (int k = 0; k < MO; k++) begin
      @(negedge clk);
      n_checks++; if (sr_valid !== 2'b10) begin n_fail++; $display("[TB] FAIL full_drain %0d: got %b expected 10", k, sr_valid); end
      @(posedge clk); #1;
    end
    mr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 3'd0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL full_empty: got outstanding %0d error %b expected 0 0", outstanding, err); end
    @(posedge clk); #1;
  endtask

  task automatic test_in_order();
    int ports[3] = '{0, 1, 0};
    logic [IW-1:0] ids[3] = '{1'b0, 1'b1, 1'b1};
    bit ok;
    int ep;
    logic [IW-1:0] eid;
    do_reset();
    exp_port_q.delete(); exp_id_q.delete();
    for (int k = 0; k < 3; k++) begin
      issue_read(ports[k], ids[k], AW'(32'h100 + k), ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL order_issue %0d: got no ready expected handshake within 10 cycles", k); end
      exp_port_q.push_back(ports[k]); exp_id_q.push_back(ids[k]);
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b1 || m_re !== 1'b1 || m_id !== ids[k] || m_addr !== AW'(32'h100 + k)) begin n_fail++; $display("[TB] FAIL order_cmd %0d: got valid %b re %b id %b addr %h expected 1 1 %b %h", k, m_valid, m_re, m_id, m_addr, ids[k], AW'(32'h100 + k)); end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      ep = exp_port_q.pop_front(); eid = exp_id_q.pop_front();
      mr_valid = 1'b1; mr_data = DW'(32'hA000 + k); mr_id = eid;
      @(negedge clk);
      n_checks++; if (mr_ready !== 1'b1 || sr_valid !== P'(1 << ep) || sr_id[ep*IW +: IW] !== eid || sr_data[ep*DW +: DW] !== DW'(32'hA000 + k)) begin n_fail++; $display("[TB] FAIL order_result %0d: got srvalid %b id %b expected %b %b", k, sr_valid, sr_id[ep*IW +: IW], P'(1 << ep), eid); end
      @(posedge clk); #1;
    end
    mr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("[TB] FAIL order_drained: got %0d expected 0", outstanding); end
    @(posedge clk); #1;
  endtask

  task automatic test_head_block();
    bit ok0, ok1;
    do_reset();
    issue_read(0, 1'b0, 32'h200, ok0);
    issue_read(1, 1'b1, 32'h204, ok1);
    sr_ready = 2'b10; mr_valid = 1'b1; mr_data = 32'h5555;
    @(negedge clk);
    n_checks++; if (!ok0 || !ok1 || outstanding !== 3'd2) begin n_fail++; $display("[TB] FAIL head_setup: got ok %b%b outstanding %0d expected 11 2", ok0, ok1, outstanding); end
    n_checks++; if (mr_ready !== 1'b0 || sr_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL head_block: got ready %b srvalid %b expected 0 01", mr_ready, sr_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("[TB] FAIL head_no_pop: got %0d expected 2", outstanding); end
    @(posedge clk); #1;
    sr_ready = 2'b11;
    @(negedge clk);
    n_checks++; if (mr_ready !== 1'b1 || sr_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL head_release: got ready %b srvalid %b expected 1 01", mr_ready, sr_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (sr_valid !== 2'b10) begin n_fail++; $display("[TB] FAIL head_next: got %b expected 10", sr_valid); end
    @(posedge clk); #1;
    mr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("[TB] FAIL head_drained: got %0d expected 0", outstanding); end
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    bit ok;
    do_reset();
    issue_read(1, 1'b0, 32'h300, ok);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (!ok || outstanding !== 3'd0 || m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_flush: got ok %b outstanding %0d mvalid %b expected 1 0 0", ok, outstanding, m_valid); end
    @(posedge clk); #1;
    mr_valid = 1'b1; mr_data = 32'hDEAD;
    @(negedge clk);
    n_checks++; if (mr_ready !== 1'b1 || sr_valid !== 2'b00 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL orphan_accept: got ready %b srvalid %b error %b expected 1 00 0", mr_ready, sr_valid, err); end
    @(posedge clk); #1;
    mr_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL error_sticky: got %b expected 1", err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL error_clear: got %b expected 0", err); end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_tracker_full();
    test_in_order();
    test_head_block();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_mux_tracked.md
MEM_MUX_TRACKED -- requirements
Module: mem_mux_tracked

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width.
REQ-003 SHALL have parameter MASK_WIDTH, default DATA_WIDTH/8: write byte-enable width.
REQ-004 SHALL have parameter ID_WIDTH, default 1: transaction id width, passed through unchanged.
REQ-005 SHALL have parameter SLAVE_PORTS, default 2: number of upstream ports; static assert SLAVE_PORTS > 1.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 4: read-tracker depth; static assert power of 2 and >= 2.
REQ-007 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-008 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-009 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-010 SHALL have port slave_command[SLAVE_PORTS], std_mem_intf.in: upstream commands (valid/ready, read_enable, write_enable, addr, data, id).
REQ-011 SHALL have port slave_result[SLAVE_PORTS], std_mem_intf.out: upstream read results (valid/ready, data, id).
REQ-012 SHALL have port master_command, std_mem_intf.out: merged downstream commands.
REQ-013 SHALL have port master_result, std_mem_intf.in: downstream read results, returned in command order.
REQ-014 SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING)+1: current tracker occupancy.
REQ-015 SHALL have port error, output, 1: sticky flag, set by a result arriving with an empty tracker.

Function
REQ-016 Command output SHALL be a single register stage: slave handshake in cycle N gives master_command.valid in cycle N+1.
REQ-017 Output register SHALL accept a new grant when empty or when master_command handshakes in the same cycle (full throughput, one command per cycle).
REQ-018 At most one slave_command[i].ready SHALL be high per cycle, and only for the granted port.
REQ-019 A port SHALL be eligible when valid; a read command (read_enable=1) SHALL additionally require tracker count < MAX_OUTSTANDING; write-only commands ignore tracker fullness.
REQ-020 Round-robin: search SHALL start at last_granted+1 modulo SLAVE_PORTS; last_granted updates only on handshake.
REQ-021 Fixed mode: the lowest-index eligible port SHALL win; a starved higher port is permitted.
REQ-022 On grant of a read, the granted port index SHALL be pushed into the tracker FIFO in the same cycle.
REQ-023 master_result SHALL route to slave_result[head]; master_result.ready = slave_result[head].ready when tracker non-empty.
REQ-024 A master_result handshake SHALL pop the tracker; push and pop in the same cycle leave the count unchanged.
REQ-025 A full tracker SHALL block read grants even if a pop occurs that cycle (no same-cycle bypass).
REQ-026 Tracker pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-027 master_result.valid with an empty tracker SHALL be accepted (ready=1), dropped and set error; error clears only on reset.
REQ-028 Non-head slave_result[i].valid SHALL be 0; id and data pass through unmodified.

Reset
REQ-029 While rst=0 at a clock edge: master_command.valid=0, all slave_command ready=0, all slave_result valid=0, tracker empty, outstanding=0, error=0, last_granted=SLAVE_PORTS-1.
REQ-030 Reset mid-transaction SHALL discard the registered command and all tracker entries; late master_result after reset is handled per REQ-027.

Structure
REQ-031 ARB_MODE encoding constants SHALL live in the shared std_mem package.
REQ-032 Tracker SHALL be a sub-module mem_mux_order_fifo (width $clog2(SLAVE_PORTS), depth MAX_OUTSTANDING, count output).

Verification
REQ-033 Ports 0,1 valid continuously, writes, ARB_MODE=0 -> grants alternate 0,1,0,1; one master command per cycle after the first.
REQ-034 Same stimulus, ARB_MODE=1 -> port 0 granted every cycle, port 1 ready stays 0.
REQ-035 MAX_OUTSTANDING=4, 5 reads from port 1, master_result.valid held 0 -> 4 accepted, outstanding=4, 5th ready=0 until first result handshake.
REQ-036 Reads port0 id=0, port1 id=1, port0 id=1; results returned in order -> delivered to slave_result 0,1,0 with matching ids; outstanding back to 0.
REQ-037 Head port ready=0 with result valid -> master_result.ready=0, no pop, other ports' results not delivered.
REQ-038 master_result.valid with tracker empty -> accepted, no slave_result valid, error=1 until rst=0.
